alu_rr_sequencer: RTL

Hard-wired micro-sequencer for the register-register class of the CPU. It drives the bus-based datapath control strobes through the fetch and execute steps: T0 PC→MAR, T1 memory read, T2 MDR→IR, then the execute steps. It replaces hand-driven T-state control and generalises it in three ways: parametrised register count, variable-latency memory handshake, and separate modes for two-operand, one-operand and 64-bit-result (MUL/DIV) instructions.

---
 rtl/cpu_pkg.sv | 66 ++++++
 rtl/reg_onehot_dec.sv | 20 ++
 rtl/alu_rr_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, IR field positions, sequencer state encoding
// and the instruction-class decode used by the register-register sequencer.
package cpu_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b10010;

  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;
  localparam int IR_REG_W  = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T0   = 3'd1;
  localparam logic [2:0] ST_T1   = 3'd2;
  localparam logic [2:0] ST_T2   = 3'd3;
  localparam logic [2:0] ST_T3   = 3'd4;
  localparam logic [2:0] ST_T4   = 3'd5;
  localparam logic [2:0] ST_T5   = 3'd6;
  localparam logic [2:0] ST_T6   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_T0   = ST_T0,
    S_T1   = ST_T1,
    S_T2   = ST_T2,
    S_T3   = ST_T3,
    S_T4   = ST_T4,
    S_T5   = ST_T5,
    S_T6   = ST_T6
  } state_t;

  typedef enum logic [1:0] {
    CLS_TWO_OP  = 2'd0,
    CLS_ONE_OP  = 2'd1,
    CLS_MULDIV  = 2'd2,
    CLS_ILLEGAL = 2'd3
  } instr_class_t;

  function automatic instr_class_t instr_class(input logic [OPCODE_W-1:0] op);
    instr_class_t cls;
    cls = CLS_ILLEGAL;
    if (op >= OP_ADD && op <= OP_ROL)
      cls = CLS_TWO_OP;
    else if (op == OP_NEG || op == OP_NOT)
      cls = CLS_ONE_OP;
    else if (op == OP_MUL || op == OP_DIV)
      cls = CLS_MULDIV;
    return cls;
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot select decoder; index is taken modulo REGS and
// the whole vector is zero when the enable is low.
module reg_onehot_dec #(
  parameter int RSEL = 4,
  parameter int REGS = 16
) (
  input  logic            en,
  input  logic [RSEL-1:0] idx,
  output logic [REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < REGS; i++) begin
      if (en && ((int'(idx) % REGS) == i))
        onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Hard-wired fetch/execute sequencer for register-register instructions,
// producing Moore datapath strobes from the T-state register.
module alu_rr_sequencer
  import cpu_pkg::*;
#(
  parameter int REGS     = 16,
  parameter int RSEL     = 4,
  parameter int OPW      = 5,
  parameter int WAIT_MAX = 15
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic            run,
  input  logic            mem_ready,
  input  logic [31:0]     ir,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            HIin,
  output logic            LOin,
  output logic [REGS-1:0] Rin,
  output logic [REGS-1:0] Rout,
  output logic [OPW-1:0]  alu_op,
  output logic            done,
  output logic            illegal,
  output logic            bus_error,
  output state_t          state_dbg
);

  // Handshake: run is a start request sampled only in IDLE; done is a
  // one-cycle retire pulse with no acknowledge, so a run held high across
  // done starts the next instruction only after one IDLE cycle.

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX);

  state_t          state, state_nxt;
  logic [CW-1:0]   wait_cnt;
  logic [OPCODE_W-1:0] opcode;
  instr_class_t    cls;
  logic [RSEL-1:0] ra_idx, rb_idx, rc_idx;
  logic            rin_en, rout_en;
  logic [RSEL-1:0] rin_idx, rout_idx;
  logic            unused_ir;

  assign opcode    = ir[IR_OP_LSB +: OPCODE_W];
  assign ra_idx    = RSEL'(ir[IR_RA_LSB +: IR_REG_W]);
  assign rb_idx    = RSEL'(ir[IR_RB_LSB +: IR_REG_W]);
  assign rc_idx    = RSEL'(ir[IR_RC_LSB +: IR_REG_W]);
  assign cls       = instr_class(opcode);
  assign unused_ir = ^ir[IR_RC_LSB-1:0];
  assign state_dbg = state;

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Counter sits at zero outside T1, so every T1 entry starts a fresh count.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear)
      wait_cnt <= '0;
    else if (state != S_T1)
      wait_cnt <= '0;
    else if (!mem_ready && wait_cnt != WAIT_LAST)
      wait_cnt <= wait_cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    PCout     = 1'b0;
    MARin     = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    rin_en    = 1'b0;
    rout_en   = 1'b0;
    rin_idx   = ra_idx;
    rout_idx  = rb_idx;
    alu_op    = '0;
    done      = 1'b0;
    illegal   = 1'b0;
    bus_error = 1'b0;
    case (state)
      S_IDLE: begin
        if (run)
          state_nxt = S_T0;
      end
      S_T0: begin
        PCout     = 1'b1;
        MARin     = 1'b1;
        IncPC     = 1'b1;
        Zin       = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        // Timeout wins even if mem_ready arrives in the same cycle.
        if (wait_cnt == WAIT_LAST) begin
          bus_error = 1'b1;
          state_nxt = S_IDLE;
        end else if (mem_ready) begin
          state_nxt = S_T2;
        end
      end
      S_T2: begin
        MDRout    = 1'b1;
        IRin      = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        case (cls)
          CLS_TWO_OP: begin
            rout_en   = 1'b1;
            Yin       = 1'b1;
            state_nxt = S_T4;
          end
          CLS_MULDIV: begin
            rout_en   = 1'b1;
            rout_idx  = ra_idx;
            Yin       = 1'b1;
            state_nxt = S_T4;
          end
          CLS_ONE_OP: begin
            rout_en   = 1'b1;
            Zin       = 1'b1;
            alu_op    = OPW'(opcode);
            state_nxt = S_T5;
          end
          default: begin
            illegal   = 1'b1;
            state_nxt = S_IDLE;
          end
        endcase
      end
      S_T4: begin
        rout_en   = 1'b1;
        rout_idx  = (cls == CLS_MULDIV) ? rb_idx : rc_idx;
        Zin       = 1'b1;
        alu_op    = OPW'(opcode);
        state_nxt = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (cls == CLS_MULDIV) begin
          LOin      = 1'b1;
          state_nxt = S_T6;
        end else begin
          rin_en    = 1'b1;
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_T6: begin
        Zhighout  = 1'b1;
        HIin      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  reg_onehot_dec #(.RSEL(RSEL), .REGS(REGS)) u_rin_dec (
    .en     (rin_en),
    .idx    (rin_idx),
    .onehot (Rin)
  );

  reg_onehot_dec #(.RSEL(RSEL), .REGS(REGS)) u_rout_dec (
    .en     (rout_en),
    .idx    (rout_idx),
    .onehot (Rout)
  );

endmodule
